// File: rtl/cprv_id_stage.sv
// cprv_id_stage: instruction-decode stage of the cprv64g in-order pipeline.
//
// Decodes one RV64I instruction per cycle from IF. It reads operands from an
// internal 32 x DATA_WIDTH register file that writeback fills. A busy-bit
// scoreboard stalls RAW/WAW hazards. The decoded payload is registered for EX.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   valid_id_i / ready_id_o    instruction handshake from IF
//   instr_data_id_i, pc_id_i   instruction word and its PC
//   valid_ex_o / ready_ex_i    payload handshake to EX
//   pc_ex_o, rs1_data_ex_o, rs2_data_ex_o, imm_ex_o, rd_ex_o, rd_we_ex_o,
//   funct3_ex_o, alt_ex_o, opclass_ex_o, illegal_ex_o   registered payload
//   wb_en_i, wb_rd_i, wb_data_i   register-file write port from writeback
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. A producer holds valid and its payload stable until that edge. Ready
// may depend combinationally on valid. Here the output stage advances (cke)
// whenever it is empty or EX takes the current payload. IF is accepted only
// when the stage advances and the instruction has no outstanding hazard.
module cprv_id_stage #(
   parameter int INSTR_WIDTH = 32,
   parameter int DATA_WIDTH  = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   valid_id_i,
   output logic                   ready_id_o,
   input  logic [INSTR_WIDTH-1:0] instr_data_id_i,
   input  logic [DATA_WIDTH-1:0]  pc_id_i,
   output logic                   valid_ex_o,
   input  logic                   ready_ex_i,
   output logic [DATA_WIDTH-1:0]  pc_ex_o,
   output logic [DATA_WIDTH-1:0]  rs1_data_ex_o,
   output logic [DATA_WIDTH-1:0]  rs2_data_ex_o,
   output logic [DATA_WIDTH-1:0]  imm_ex_o,
   output logic [4:0]             rd_ex_o,
   output logic                   rd_we_ex_o,
   output logic [2:0]             funct3_ex_o,
   output logic                   alt_ex_o,
   output logic [3:0]             opclass_ex_o,
   output logic                   illegal_ex_o,
   input  logic                   wb_en_i,
   input  logic [4:0]             wb_rd_i,
   input  logic [DATA_WIDTH-1:0]  wb_data_i
);

   typedef enum logic [3:0] {
      OC_LUI       = 4'd0,
      OC_AUIPC     = 4'd1,
      OC_JAL       = 4'd2,
      OC_JALR      = 4'd3,
      OC_BRANCH    = 4'd4,
      OC_LOAD      = 4'd5,
      OC_STORE     = 4'd6,
      OC_OP_IMM    = 4'd7,
      OC_OP        = 4'd8,
      OC_OP_IMM_32 = 4'd9,
      OC_OP_32     = 4'd10,
      OC_MISC_MEM  = 4'd11,
      OC_SYSTEM    = 4'd12,
      OC_ILLEGAL   = 4'd15
   } opclass_t;

   // ---------------- field extraction ----------------
   logic [31:0] instr;
   logic [6:0]  opcode;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;

   assign instr  = instr_data_id_i[31:0];
   assign opcode = instr[6:0];
   assign rd     = instr[11:7];
   assign funct3 = instr[14:12];
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];

   logic [DATA_WIDTH-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   assign imm_i = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
   assign imm_s = {{(DATA_WIDTH-12){instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{(DATA_WIDTH-13){instr[31]}}, instr[31], instr[7],
                   instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {{(DATA_WIDTH-32){instr[31]}}, instr[31:12], 12'h000};
   assign imm_j = {{(DATA_WIDTH-21){instr[31]}}, instr[31], instr[19:12],
                   instr[20], instr[30:21], 1'b0};

   // ---------------- decode ----------------
   opclass_t              opclass;
   logic                  uses_rs1, uses_rs2, writes_rd, rd_we;
   logic [DATA_WIDTH-1:0] imm;

   always_comb begin
      opclass   = OC_ILLEGAL;
      uses_rs1  = 1'b0;
      uses_rs2  = 1'b0;
      writes_rd = 1'b0;
      imm       = '0;
      if (instr[1:0] == 2'b11) begin
         case (opcode)
            7'b0110111: begin opclass = OC_LUI;   writes_rd = 1'b1; imm = imm_u; end
            7'b0010111: begin opclass = OC_AUIPC; writes_rd = 1'b1; imm = imm_u; end
            7'b1101111: begin opclass = OC_JAL;   writes_rd = 1'b1; imm = imm_j; end
            7'b1100111: begin
               opclass = OC_JALR; uses_rs1 = 1'b1; writes_rd = 1'b1; imm = imm_i;
            end
            7'b1100011: begin
               opclass = OC_BRANCH; uses_rs1 = 1'b1; uses_rs2 = 1'b1; imm = imm_b;
            end
            7'b0000011: begin
               opclass = OC_LOAD; uses_rs1 = 1'b1; writes_rd = 1'b1; imm = imm_i;
            end
            7'b0100011: begin
               opclass = OC_STORE; uses_rs1 = 1'b1; uses_rs2 = 1'b1; imm = imm_s;
            end
            7'b0010011: begin
               opclass = OC_OP_IMM; uses_rs1 = 1'b1; writes_rd = 1'b1; imm = imm_i;
            end
            7'b0110011: begin
               opclass = OC_OP; uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes_rd = 1'b1;
            end
            7'b0011011: begin
               opclass = OC_OP_IMM_32; uses_rs1 = 1'b1; writes_rd = 1'b1; imm = imm_i;
            end
            7'b0111011: begin
               opclass = OC_OP_32; uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes_rd = 1'b1;
            end
            7'b0001111: opclass = OC_MISC_MEM;
            7'b1110011: begin
               // No CSR support: only ECALL/EBREAK-style funct3==0 is legal.
               if (funct3 == 3'b000) begin
                  opclass = OC_SYSTEM;
                  imm     = imm_i;
               end
            end
            default: ;
         endcase
      end
      rd_we = writes_rd & (rd != 5'd0);
   end

   // ---------------- register file ----------------
   logic [DATA_WIDTH-1:0] regs [32];
   logic [DATA_WIDTH-1:0] rs1_val, rs2_val;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (wb_en_i && (wb_rd_i != 5'd0)) begin
         regs[wb_rd_i] <= wb_data_i;
      end
   end

   // Same-cycle writeback is bypassed so a hazard cleared this cycle reads
   // the value that is being written.
   assign rs1_val = (rs1 == 5'd0) ? '0 :
                    (wb_en_i && (wb_rd_i == rs1)) ? wb_data_i : regs[rs1];
   assign rs2_val = (rs2 == 5'd0) ? '0 :
                    (wb_en_i && (wb_rd_i == rs2)) ? wb_data_i : regs[rs2];

   // ---------------- scoreboard and handshake ----------------
   logic [31:0] busy, clear_vec, set_vec, eff_busy;
   logic        hazard, cke, issue;

   assign clear_vec = wb_en_i ? (32'd1 << wb_rd_i) : 32'd0;
   assign eff_busy  = busy & ~clear_vec;
   assign hazard    = (uses_rs1 & eff_busy[rs1]) | (uses_rs2 & eff_busy[rs2]) |
                      (rd_we & eff_busy[rd]);

   assign cke        = ~valid_ex_o | ready_ex_i;
   assign ready_id_o = cke & ~(valid_id_i & hazard);
   assign issue      = valid_id_i & ready_id_o;
   assign set_vec    = (issue && rd_we) ? (32'd1 << rd) : 32'd0;

   // Set is applied after clear so a same-register collision stays busy.
   // Bit 0 is forced low: x0 never carries a hazard.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy <= '0;
      else        busy <= ((busy & ~clear_vec) | set_vec) & 32'hFFFF_FFFE;
   end

   // ---------------- payload to EX ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_ex_o    <= 1'b0;
         pc_ex_o       <= '0;
         rs1_data_ex_o <= '0;
         rs2_data_ex_o <= '0;
         imm_ex_o      <= '0;
         rd_ex_o       <= '0;
         rd_we_ex_o    <= 1'b0;
         funct3_ex_o   <= '0;
         alt_ex_o      <= 1'b0;
         opclass_ex_o  <= '0;
         illegal_ex_o  <= 1'b0;
      end else if (cke) begin
         valid_ex_o <= issue;
         if (issue) begin
            pc_ex_o       <= pc_id_i;
            rs1_data_ex_o <= rs1_val;
            rs2_data_ex_o <= rs2_val;
            imm_ex_o      <= imm;
            rd_ex_o       <= rd;
            rd_we_ex_o    <= rd_we;
            funct3_ex_o   <= funct3;
            alt_ex_o      <= instr[30];
            opclass_ex_o  <= opclass;
            illegal_ex_o  <= (opclass == OC_ILLEGAL);
         end
      end
   end

endmodule

// File: doc/cprv_id_stage.md
# cprv_id_stage

Instruction-decode stage of the cprv64g in-order pipeline, sitting between the instruction-fetch stage and the execute stage. It accepts one 32-bit RV64I instruction plus its PC over a valid/ready handshake and decodes opcode class, fields and immediate. It reads operands from an internal 32x64 integer register file, which takes writes from writeback. A busy-bit scoreboard stalls RAW/WAW hazards, and a registered payload goes to EX.

## Interface
- INSTR_WIDTH, 32, instruction width
- DATA_WIDTH, 64, XLEN / register and PC width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- valid_id_i  in  1  instruction from IF valid
- ready_id_o  out  1  ID accepts instruction this cycle
- instr_data_id_i  in  INSTR_WIDTH  instruction word
- pc_id_i  in  DATA_WIDTH  PC of instruction
- valid_ex_o  out  1  payload to EX valid
- ready_ex_i  in  1  EX accepts payload
- pc_ex_o  out  DATA_WIDTH  forwarded PC
- rs1_data_ex_o, rs2_data_ex_o  out  DATA_WIDTH  operand values
- imm_ex_o  out  DATA_WIDTH  sign-extended immediate
- rd_ex_o  out  5  destination register
- rd_we_ex_o  out  1  instruction writes rd
- funct3_ex_o  out  3  instr[14:12]
- alt_ex_o  out  1  instr[30] (SUB/SRA select)
- opclass_ex_o  out  4  0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 OP_IMM, 8 OP, 9 OP_IMM_32, 10 OP_32, 11 MISC_MEM, 12 SYSTEM, 15 ILLEGAL
- illegal_ex_o  out  1  opclass is ILLEGAL
- wb_en_i  in  1  writeback strobe
- wb_rd_i  in  5  writeback register
- wb_data_i  in  DATA_WIDTH  writeback value

## Operation
- Decode is combinational on instr_data_id_i. ILLEGAL applies when instr[1:0]!=2'b11, the opcode is unlisted, or SYSTEM has funct3!=0 (no CSRs).
- Immediates follow the standard RISC-V formats. I: JALR, LOAD, OP_IMM, OP_IMM_32, SYSTEM. S: STORE. B: BRANCH. U: LUI, AUIPC. J: JAL. All are sign-extended to 64 bits. Other classes produce imm 0.
- Register usage:
  - uses_rs1: JALR, BRANCH, LOAD, STORE, OP_IMM, OP, OP_IMM_32, OP_32.
  - uses_rs2: BRANCH, STORE, OP, OP_32.
  - rd_we: LUI, AUIPC, JAL, JALR, LOAD, OP_IMM, OP, OP_IMM_32, OP_32, and only when rd!=0.
- Register file:
  - 32x64 with asynchronous read.
  - x0 always reads 0, and writes to x0 are dropped.
  - A write is performed on a clk edge when wb_en_i=1.
  - Same-cycle bypass: if wb_en_i and wb_rd_i==rs (rs!=0), the read returns wb_data_i.
- Scoreboard: busy[31:1] holds one bit per register.
  - clear_vec = wb_en_i ? onehot(wb_rd_i) : 0.
  - eff_busy = busy & ~clear_vec.
  - hazard = (uses_rs1 & eff_busy[rs1]) | (uses_rs2 & eff_busy[rs2]) | (rd_we & eff_busy[rd]).
- Handshake:
  - cke = ~valid_ex_o | ready_ex_i.
  - ready_id_o = cke & ~(valid_id_i & hazard).
  - issue = valid_id_i & ready_id_o.
- On cke: valid_ex_o <= issue. When issue=1, all payload registers load the decoded values. When issue=0, the payload holds.
- On issue with rd_we: busy[rd] is set. Clear and set on the same register in the same cycle resolve to set.
- On wb_en_i: busy[wb_rd_i] is cleared unless it is set by issue in that cycle.
- ILLEGAL instructions issue normally: illegal_ex_o=1, rd_we 0, no scoreboard effect, no hazard check.

## Timing
- Latency is one cycle: an instruction accepted at edge N appears on valid_ex_o after edge N.
- Full throughput: one instruction per cycle when there is no hazard and EX is ready.
- EX backpressure: while valid_ex_o=1 and ready_ex_i=0, all _ex_o outputs are held stable and ready_id_o=0.
- Hazard stall: ready_id_o=0 while the hazard persists. IF holds the instruction. valid_ex_o drops to 0 on the next cke edge, inserting a bubble.
- A writeback arriving in the same cycle resolves the hazard in that cycle: the instruction issues with the bypassed value.
- Reset (async assert, any time, including mid-stall):
  - valid_ex_o=0 and ready_id_o reflects cke=1.
  - All payload outputs are 0.
  - All busy bits are 0.
  - All registers are 0.
- Reset deassertion is synchronous to clk by the system.

## Test plan
- Reset then issue ADDI x1,x0,5 (0x00500093) at PC 0x0 with ready_ex_i=1.
  - Required, next cycle: valid_ex_o=1, opclass 7, imm 5, rd 1, rd_we 1, rs1_data 0, busy[1]=1.
- Back-to-back ADDI x1 then ADD x2,x1,x1 (0x00108133).
  - Required: ready_id_o=0 until wb_en_i/wb_rd_i=1/wb_data_i=5.
  - In that same cycle ADD issues with rs1_data=rs2_data=5.
- Hold ready_ex_i=0 for 3 cycles with the payload valid.
  - Required: the payload is stable, ready_id_o=0, and no new instruction is accepted.
  - Release: the next instruction issues the following edge.
- Immediates:
  - BEQ x0,x0,-4 (0xFE000EE3) yields imm 0xFFFF_FFFF_FFFF_FFFC.
  - LUI x5,0x80000 (0x800002B7) yields imm 0xFFFF_FFFF_8000_0000.
- Instruction 0x00000000 yields opclass 15, illegal_ex_o=1, rd_we 0, and no stall.
  - A write to x0 via wb_en_i leaves x0 reading 0.
- Assert rst_n=0 while stalled on a hazard.
  - Required: valid_ex_o=0 and all busy bits clear immediately.
  - After release, the same instruction issues without stall.
